// File: rtl/cla_pkg.sv
// Shared types and sizes for the cacheline <-> bmem burst adapter.
// A 256-bit line moves as four 64-bit beats, beat 0 in the low bits.
package cla_pkg;
    localparam int ADDR_W     = 32;
    localparam int LINE_W     = 256;
    localparam int BEAT_W     = 64;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_BEATS,
        RESP
    } cla_state_t;
endpackage

// File: rtl/cacheline_adapter.sv
// Converts one cacheline read/write into a 4-beat bmem burst.
// One transaction in flight; read data returns with its line address.
module cacheline_adapter
    import cla_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cla_addr,
    input  logic              cla_read,
    input  logic              cla_write,
    input  logic [LINE_W-1:0] cla_wdata,
    output logic [LINE_W-1:0] cla_rdata,
    output logic [ADDR_W-1:0] cla_raddr,
    output logic              cla_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam logic [BEAT_IDX_W-1:0] LAST = BEAT_IDX_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    cla_state_t              state_q, state_d;
    logic [BEAT_IDX_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [BEAT_W-1:0]       buf_q [BEATS];
    logic [BEAT_W-1:0]       buf_d [BEATS];
    logic [LINE_W-1:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0]       raddr_q, raddr_d;
    logic [ADDR_W-1:0]       line_addr;
    logic                    wr_start;

    assign line_addr = cla_addr & ALIGN_MASK;
    assign wr_start  = (state_q == IDLE) && cla_write && !cla_read;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        rdata_d    = rdata_q;
        raddr_d    = raddr_q;
        unique case (state_q)
            IDLE: begin
                if (cla_read) begin
                    if (bmem_ready) begin
                        addr_d     = line_addr;
                        beat_cnt_d = '0;
                        state_d    = RD_WAIT;
                    end
                end else if (cla_write && bmem_ready) begin
                    addr_d = line_addr;
                    for (int i = 0; i < BEATS; i++)
                        buf_d[i] = cla_wdata[i*BEAT_W +: BEAT_W];
                    beat_cnt_d = BEAT_IDX_W'(1);
                    state_d    = WR_BEATS;
                end
            end
            RD_WAIT: begin
                if (bmem_rvalid) begin
                    buf_d[beat_cnt_q] = bmem_rdata;
                    beat_cnt_d = beat_cnt_q + BEAT_IDX_W'(1);
                    if (beat_cnt_q == LAST) begin
                        for (int i = 0; i < BEATS; i++)
                            rdata_d[i*BEAT_W +: BEAT_W] = buf_d[i];
                        raddr_d = bmem_raddr;
                        state_d = RESP;
                    end
                end
            end
            WR_BEATS: begin
                beat_cnt_d = beat_cnt_q + BEAT_IDX_W'(1);
                if (beat_cnt_q == LAST) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            raddr_q    <= '0;
            for (int i = 0; i < BEATS; i++) buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            raddr_q    <= raddr_d;
            for (int i = 0; i < BEATS; i++) buf_q[i] <= buf_d[i];
        end
    end

    // bmem strobes are forced low while reset is held
    always_comb begin
        bmem_addr  = (state_q == IDLE) ? line_addr : addr_q;
        bmem_read  = !rst && (state_q == IDLE) && cla_read;
        bmem_write = !rst && (wr_start || (state_q == WR_BEATS));
        bmem_wdata = '0;
        if (!rst) begin
            if (state_q == WR_BEATS) bmem_wdata = buf_q[beat_cnt_q];
            else if (wr_start)       bmem_wdata = cla_wdata[BEAT_W-1:0];
        end
    end

    assign cla_resp  = (state_q == RESP);
    assign cla_rdata = rdata_q;
    assign cla_raddr = raddr_q;

    a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
        !(cla_read && cla_write));

    a_burst_len: assert property (@(posedge clk) disable iff (rst)
        (state_q == RD_WAIT && bmem_rvalid && beat_cnt_q == LAST)
        |=> (state_q == RESP));

endmodule
